// File: rtl/plt_cfg_loader_if.sv
// Bundle of the configuration handshake and the PLT configuration/scan port.
// The loader uses the slave modport; the environment driving words and the PLT use master.
interface plt_cfg_loader_if #(
    parameter int N = 8
);
    localparam int CFG_W = 4 * (N - 1);

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CFG_W-1:0] cfg_data;
    logic [1:0]       plt_mode;
    logic             plt_config_in;
    logic             plt_scan_enable;
    logic [CFG_W-1:0] plt_scan_out;
    logic             busy;
    logic             done;
    logic             verify_err;

    modport master (
        output cfg_valid,
        output cfg_data,
        output plt_scan_out,
        input  cfg_ready,
        input  plt_mode,
        input  plt_config_in,
        input  plt_scan_enable,
        input  busy,
        input  done,
        input  verify_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        input  plt_scan_out,
        output cfg_ready,
        output plt_mode,
        output plt_config_in,
        output plt_scan_enable,
        output busy,
        output done,
        output verify_err
    );
endinterface

// File: rtl/plt_cfg_loader.sv
// PLT configuration transmitter: shifts one accepted word MSB-first into the PLT, then returns
// it to usage mode. Define PLT_CFG_VERIFY_EN to add scan readback with a sticky verify_err.
module plt_cfg_loader #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            clear_n,
    plt_cfg_loader_if.slave bus
);
    localparam int CFG_W = 4 * (N - 1);
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CFG_W - 1);

    localparam logic [1:0] MODE_CONFIG = 2'b00;
    localparam logic [1:0] MODE_USAGE  = 2'b01;
    localparam logic [1:0] MODE_TEST   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHIFT   = 3'd1,
        ST_COMMIT  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_CHECK   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CFG_W-1:0] shreg_r;
    logic [CFG_W-1:0] shreg_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;

    logic             cfg_ready_r;
    logic             cfg_ready_s;
    logic             busy_r;
    logic             busy_s;
    logic             done_r;
    logic             done_s;
    logic [1:0]       plt_mode_r;
    logic [1:0]       plt_mode_s;
    logic             plt_config_in_r;
    logic             plt_config_in_s;
    logic             plt_scan_enable_r;
    logic             plt_scan_enable_s;

`ifdef PLT_CFG_VERIFY_EN
    logic [CFG_W-1:0] latch_r;
    logic [CFG_W-1:0] latch_s;
    logic             verify_err_r;
    logic             verify_err_s;

    // The PLT loses the first shifted bit and holds the pad bit in its LSB after commit.
    function automatic logic [CFG_W-1:0] readback_image(input logic [CFG_W-1:0] word);
        return {word[CFG_W-2:0], 1'b0};
    endfunction
`endif

    // Next state, shift data and bit counter.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        cnt_s   = cnt_r;
`ifdef PLT_CFG_VERIFY_EN
        latch_s      = latch_r;
        verify_err_s = verify_err_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.cfg_valid && cfg_ready_r) begin
                    shreg_s = bus.cfg_data;
                    cnt_s   = {CNT_W{1'b0}};
`ifdef PLT_CFG_VERIFY_EN
                    latch_s = bus.cfg_data;
`endif
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                shreg_s = {shreg_r[CFG_W-2:0], 1'b0};
                cnt_s   = cnt_r + CNT_W'(1);
                if (cnt_r == LAST_BIT) begin
                    state_s = ST_COMMIT;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_COMMIT: begin
`ifdef PLT_CFG_VERIFY_EN
                state_s = ST_CAPTURE;
`else
                state_s = ST_DONE;
`endif
            end
`ifdef PLT_CFG_VERIFY_EN
            ST_CAPTURE: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (bus.plt_scan_out != readback_image(latch_r)) begin
                    verify_err_s = 1'b1;
                end else begin
                    verify_err_s = verify_err_r;
                end
                state_s = ST_DONE;
            end
`endif
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output image of the state being entered, so every output leaves a flop.
    always_comb begin
        cfg_ready_s       = 1'b0;
        busy_s            = 1'b1;
        done_s            = 1'b0;
        plt_mode_s        = MODE_USAGE;
        plt_config_in_s   = 1'b0;
        plt_scan_enable_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                cfg_ready_s = 1'b1;
                busy_s      = 1'b0;
            end
            ST_SHIFT: begin
                plt_mode_s      = MODE_CONFIG;
                plt_config_in_s = shreg_s[CFG_W-1];
            end
            ST_COMMIT: begin
                plt_mode_s = MODE_CONFIG;
            end
            ST_CAPTURE: begin
                plt_mode_s        = MODE_TEST;
                plt_scan_enable_s = 1'b1;
            end
            ST_CHECK: begin
                plt_mode_s = MODE_USAGE;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                cfg_ready_s = 1'b0;
                busy_s      = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_r           <= ST_IDLE;
            shreg_r           <= {CFG_W{1'b0}};
            cnt_r             <= {CNT_W{1'b0}};
            cfg_ready_r       <= 1'b1;
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            plt_mode_r        <= MODE_USAGE;
            plt_config_in_r   <= 1'b0;
            plt_scan_enable_r <= 1'b0;
        end else begin
            state_r           <= state_s;
            shreg_r           <= shreg_s;
            cnt_r             <= cnt_s;
            cfg_ready_r       <= cfg_ready_s;
            busy_r            <= busy_s;
            done_r            <= done_s;
            plt_mode_r        <= plt_mode_s;
            plt_config_in_r   <= plt_config_in_s;
            plt_scan_enable_r <= plt_scan_enable_s;
        end
    end

`ifdef PLT_CFG_VERIFY_EN
    // Readback reference copy and sticky mismatch flag; only clear_n clears the flag.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            latch_r      <= {CFG_W{1'b0}};
            verify_err_r <= 1'b0;
        end else begin
            latch_r      <= latch_s;
            verify_err_r <= verify_err_s;
        end
    end

    assign bus.verify_err = verify_err_r;
`else
    logic unused_scan_s;
    assign unused_scan_s  = ^bus.plt_scan_out;
    assign bus.verify_err = 1'b0;
`endif

    assign bus.cfg_ready       = cfg_ready_r;
    assign bus.busy            = busy_r;
    assign bus.done            = done_r;
    assign bus.plt_mode        = plt_mode_r;
    assign bus.plt_config_in   = plt_config_in_r;
    assign bus.plt_scan_enable = plt_scan_enable_r;
endmodule

// File: tb/tb_plt_cfg_loader.sv
// Self-checking bench for plt_cfg_loader with a behavioural PLT shift/scan model.
// Follows PLT_CFG_VERIFY_EN the same way as the design.
module tb_plt_cfg_loader;
    localparam int N     = 8;
    localparam int CFG_W = 4 * (N - 1);

    logic clk = 1'b0;
    logic clear_n;
    always #5 clk = ~clk;

    plt_cfg_loader_if #(.N(N)) bus ();

    plt_cfg_loader #(.N(N)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic             exp_verr   = 1'b0;
    logic [CFG_W-1:0] fault_mask = '0;
    logic [CFG_W-1:0] plt_sr     = '0;
    logic [CFG_W-1:0] scan_q     = '0;

    // PLT: shifts config_in while in config mode, snapshots its register on a test-mode scan
    always @(posedge clk) begin
        if (bus.plt_mode == 2'b00) begin
            plt_sr <= {plt_sr[CFG_W-2:0], bus.plt_config_in};
        end else if (bus.plt_mode == 2'b10 && bus.plt_scan_enable) begin
            scan_q <= plt_sr ^ fault_mask;
        end
    end
    assign bus.plt_scan_out = scan_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(bus.cfg_ready), 32'd1);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_mode"},  32'(bus.plt_mode), 32'd1);
        check({tag, "_cfgin"}, 32'(bus.plt_config_in), 32'd0);
        check({tag, "_scan"},  32'(bus.plt_scan_enable), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_verr"},  32'(bus.verify_err), 32'(exp_verr));
    endtask

    // Entered and left on a falling edge with the loader idle.
    task automatic load_word(input logic [CFG_W-1:0] w, input bit hold_valid, input bit scramble,
                             input logic [CFG_W-1:0] next_w, input logic [CFG_W-1:0] mask);
        check_idle("pre_load");
        fault_mask    = mask;
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = hold_valid;
        bus.cfg_data  = next_w;
        for (int k = 0; k < CFG_W; k++) begin
            check("shift_bit",  32'(bus.plt_config_in), 32'(w[CFG_W-1-k]));
            check("shift_mode", 32'(bus.plt_mode), 32'd0);
            check("shift_ctl",  32'({bus.cfg_ready, bus.busy, bus.done, bus.plt_scan_enable}), 32'h4);
            if (scramble) bus.cfg_data = CFG_W'($urandom);
            @(negedge clk);
        end
        check("commit_mode", 32'(bus.plt_mode), 32'd0);
        check("commit_pad",  32'(bus.plt_config_in), 32'd0);
        check("commit_ctl",  32'({bus.cfg_ready, bus.busy, bus.done, bus.plt_scan_enable}), 32'h4);
        @(negedge clk);
`ifdef PLT_CFG_VERIFY_EN
        check("capture_mode", 32'(bus.plt_mode), 32'd2);
        check("capture_ctl",  32'({bus.cfg_ready, bus.busy, bus.done, bus.plt_scan_enable}), 32'h5);
        @(negedge clk);
        check("check_mode", 32'(bus.plt_mode), 32'd1);
        check("check_ctl",  32'({bus.cfg_ready, bus.busy, bus.done, bus.plt_scan_enable}), 32'h4);
        if (mask != '0) exp_verr = 1'b1;
        @(negedge clk);
`endif
        check("done_mode", 32'(bus.plt_mode), 32'd1);
        check("done_ctl",  32'({bus.cfg_ready, bus.busy, bus.done, bus.plt_scan_enable}), 32'h6);
        check("done_verr", 32'(bus.verify_err), 32'(exp_verr));
        @(negedge clk);
        check_idle("post_load");
    endtask

    initial begin
        logic [CFG_W-1:0] w;
        clear_n       = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = '0;

        // Reset values while held, then after release
        repeat (2) @(negedge clk);
        check_idle("reset");
        bus.cfg_valid = 1'b1;
        @(negedge clk);
        check_idle("reset_valid_ignored");
        bus.cfg_valid = 1'b0;
        clear_n = 1'b1;
        @(negedge clk);
        check_idle("released");

        // Reference word from the test plan
        load_word(28'h6A5C3F1, 1'b0, 1'b0, '0, '0);

        // Corrupted readback on bit 5, then a good load: flag must stay set
        load_word(CFG_W'($urandom), 1'b0, 1'b0, '0, 28'h0000020);
        load_word(CFG_W'($urandom), 1'b0, 1'b0, '0, '0);

        // cfg_valid held high with alternating words: one accept per IDLE cycle
        for (int i = 0; i < 4; i++) begin
            w = (i % 2 == 0) ? 28'hFFFFFFF : 28'h0000000;
            load_word(w, (i != 3), 1'b0, ~w, '0);
        end
        bus.cfg_valid = 1'b0;

        // Input word churning during SHIFT must not disturb the stream
        for (int i = 0; i < 3; i++) load_word(CFG_W'($urandom), 1'b0, 1'b1, CFG_W'($urandom), '0);

        // Random words
        for (int i = 0; i < 4; i++) load_word(CFG_W'($urandom), 1'b0, 1'b0, '0, '0);

        // clear_n pulsed during SHIFT cycle 10
        w = 28'hC3A5F0E;
        check_idle("pre_abort");
        bus.cfg_valid = 1'b1;
        bus.cfg_data  = w;
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_bit", 32'(bus.plt_config_in), 32'(w[CFG_W-10]));
        check("abort_mode", 32'(bus.plt_mode), 32'd0);
        #1 clear_n = 1'b0;
        exp_verr = 1'b0;
        #1 check_idle("abort_immediate");
        @(negedge clk);
        check_idle("abort_held");
        clear_n = 1'b1;
        load_word(28'h1234567, 1'b0, 1'b0, '0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/plt_cfg_loader.md
# plt_cfg_loader

Configuration transmitter for the PLT (programmable LUT tree). It accepts one parallel configuration word through a valid/ready handshake and drives it MSB-first onto the PLT serial configuration port, sequencing the PLT `mode` and `scan_enable` lines. It then returns the PLT to usage mode. Optionally, it reads the configuration back through the PLT test-mode scan path and flags any mismatch.

## Interface
- `N`, 8: PLT input count (power of 2, ≥ 2); must match the attached PLT.
- `CFG_W`, 4*(N-1): configuration word width (localparam, derived; 28 for N=8).

Ports:
- `clk`  in  1  single clock, rising edge.
- `clear_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  a configuration word is offered.
- `cfg_ready`  out  1  loader can accept a word; high only in IDLE.
- `cfg_data`  in  CFG_W  configuration word; bits [4i+3:4i] belong to LUT i.
- `plt_mode`  out  2  drives PLT `mode`; 00 = config, 01 = usage, 10 = test.
- `plt_config_in`  out  1  drives PLT `config_in`.
- `plt_scan_enable`  out  1  drives PLT `scan_enable`.
- `plt_scan_out`  in  CFG_W  from PLT `scan_out`; used only with VERIFY_EN.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse at the end of each load.
- `verify_err`  out  1  sticky readback-mismatch flag; constant 0 without VERIFY_EN.

## Operation
- States: IDLE → SHIFT → COMMIT → [CAPTURE → CHECK] → DONE → IDLE. The bracketed states exist only with VERIFY_EN.
- Outputs are decoded directly from registered state and registered data; there is no combinational path from any input to any output.
- IDLE
  - Outputs: `cfg_ready`=1, `plt_mode`=01, `plt_config_in`=0, `plt_scan_enable`=0.
  - On an edge with `cfg_valid`&`cfg_ready`: latch `cfg_data` into the shift register, clear the bit counter, and go to SHIFT.
  - `cfg_valid` without `cfg_ready` is ignored; the word is not queued.
- SHIFT
  - Outputs: `plt_mode`=00, `plt_scan_enable`=0, `plt_config_in`=shreg[CFG_W-1].
  - Each edge shifts the register left, filling with 0, and increments the counter.
  - After CFG_W edges, go to COMMIT.
  - The counter is $clog2(CFG_W+1) bits wide and does not wrap within a load.
- COMMIT
  - Outputs: `plt_mode`=00, `plt_config_in`=0 (pad bit).
  - Purpose: the PLT copies its shifted bits into its LUTs one edge after they arrive, so this extra edge is required. The PLT shift register then holds {cfg_data[CFG_W-2:0],1'b0}.
  - Next state: CAPTURE with VERIFY_EN, otherwise DONE.
- CAPTURE: `plt_mode`=10, `plt_scan_enable`=1 for exactly one cycle; the PLT registers its shift register onto `scan_out` at this edge.
- CHECK
  - Outputs: `plt_mode`=01, `plt_scan_enable`=0.
  - Compare `plt_scan_out` against {latched cfg_data[CFG_W-2:0],1'b0}. On inequality, set `verify_err`.
  - Go to DONE.
- DONE: `plt_mode`=01, `done`=1 for one cycle, then IDLE.
- `verify_err` clears only on `clear_n`; it stays set across subsequent good loads.
- The loader never drives the PLT `clear` input.

## Timing
- Reset values (asynchronous on `clear_n`=0): state=IDLE, shreg=0, counter=0, `cfg_ready`=1, `plt_mode`=01, `plt_config_in`=0, `plt_scan_enable`=0, `busy`=0, `done`=0, `verify_err`=0.
- Let E0 be the accept edge.
  - Bit CFG_W-1-k is on `plt_config_in` during cycle k+1 after E0 (k=0..CFG_W-1).
  - COMMIT occupies the cycle after E0+CFG_W.
  - `done` is high after E0+CFG_W+1 (no verify) or E0+CFG_W+3 (verify).
  - `cfg_ready` rises one edge later.
- Load cost: CFG_W+2 cycles, or CFG_W+4 with verify. Back-to-back loads therefore have one IDLE cycle between them.
- A `cfg_data` change after E0 does not affect an in-flight load.
- `clear_n` asserted mid-load: immediate return to reset values. The PLT keeps a partial configuration; recovery is a new load.
- `clear_n` deassertion is synchronized externally; the first accept can occur at the first edge after release.

## Configuration
- `PLT_CFG_VERIFY_EN`
  - Defined: CAPTURE and CHECK states are present, `plt_scan_out` is compared, `verify_err` is live, and a load costs CFG_W+4 cycles.
  - Undefined: COMMIT goes straight to DONE, `plt_scan_out` is unused, `verify_err` is tied to 0, and a load costs CFG_W+2 cycles.

## Test plan
- Reset: hold `clear_n`=0 → all outputs at reset values. Release → `cfg_ready`=1, `plt_mode`=01.
- N=8 load of 28'h6A5C3F1 → `plt_config_in` serial sequence 0110_1010_0101_1100_0011_1111_0001 over 28 cycles with `plt_mode`=00, then a pad 0. `done` is high at cycle 30, `cfg_ready` at 31. The attached PLT then computes the expected tree output for `data_in`=8'hB4.
- VERIFY_EN with a correct PLT → `plt_scan_enable` high for one cycle with `plt_mode`=10, `verify_err`=0, `done` at cycle 32. Force bit 5 of `plt_scan_out` wrong → `verify_err`=1 and it stays 1 through a following good load.
- `cfg_valid` held high continuously with alternating words 28'hFFFFFFF/28'h0000000 → each word accepted only in IDLE, with exactly one IDLE cycle between loads and no word lost or duplicated.
- `clear_n` pulsed low at SHIFT cycle 10 → outputs immediately at reset values. The next load of 28'h1234567 completes normally.
- `cfg_data` changed every cycle during SHIFT → serial stream equals the word latched at E0.
